threshold_chunk_search: RTL and testbench

Combinational-plus-register search block that scans one 8-bin chunk of a signed histogram derivative. It reports the absolute bin index of the last (highest-index) bin whose derivative is strictly positive. Thirty-two instances sit in parallel inside the last-positive threshold finder, one per 8-bin slice of the 256-bin derivative, each tagged with its chunk's base bin index. The parent selects among the per-chunk results.

---
 rtl/threshold_pkg.sv | 12 +
 rtl/last_pos_encoder.sv | 33 +++
 rtl/threshold_chunk_search.sv | 79 +++++++
 tb/tb_threshold_chunk_search.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/threshold_pkg.sv
// rtl/threshold_pkg.sv - shared sizes and types for the last-positive threshold finder
package threshold_pkg;

  localparam int BINS_PER_CHUNK = 8;
  localparam int DERIV_W        = 17;
  localparam int IDX_W          = 8;
  localparam int NUM_CHUNKS     = 32;

  typedef logic signed [DERIV_W-1:0] deriv_t;
  typedef logic        [IDX_W-1:0]   bin_idx_t;

endpackage

// File: rtl/last_pos_encoder.sv
// rtl/last_pos_encoder.sv - highest-set-bit priority encoder over a positive-bin mask
//
// Purpose: given one bit per bin (1 = derivative strictly positive), report
// whether any bit is set and the position of the highest set bit.
// Ports:
//   i_mask  [BINS]   positive-bin mask, bit k = bin k
//   o_found          at least one mask bit set
//   o_pos   [PW]     index of the highest set bit (0 when none set)
module last_pos_encoder
  import threshold_pkg::*;
#(
  parameter int BINS = BINS_PER_CHUNK,
  parameter int PW   = $clog2(BINS)
) (
  input  logic [BINS-1:0] i_mask,
  output logic            o_found,
  output logic [PW-1:0]   o_pos
);

  // Ascending scan: later (higher) bins overwrite earlier ones, so the
  // highest set bit wins.
  always_comb begin
    o_found = 1'b0;
    o_pos   = '0;
    for (int k = 0; k < BINS; k++) begin
      if (i_mask[k]) begin
        o_found = 1'b1;
        o_pos   = PW'(k);
      end
    end
  end

endmodule

// File: rtl/threshold_chunk_search.sv
// rtl/threshold_chunk_search.sv - registered last-positive-bin search over one histogram chunk
//
// Purpose: report the absolute index of the highest bin in this chunk whose
// signed derivative is strictly positive (0 when none), one cycle after input.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_valid               chunk/index valid this cycle
//   i_histogram_chunk     BINS packed signed DW-bit samples, bin 0 at LSBs
//   i_bin_index           absolute index of bin 0 of this chunk
//   o_threshold           registered result, holds when i_valid=0
//   o_valid               i_valid delayed by one cycle
module threshold_chunk_search
  import threshold_pkg::*;
#(
  parameter int TOP  = 1,
  parameter int BINS = BINS_PER_CHUNK,
  parameter int DW   = DERIV_W
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [BINS*DW-1:0] i_histogram_chunk,
  input  bin_idx_t           i_bin_index,
  output bin_idx_t           o_threshold,
  output logic               o_valid
);

  localparam int PW = $clog2(BINS);

  logic [BINS-1:0] pos_mask;
  logic            found;
  logic [PW-1:0]   pos;
  bin_idx_t        threshold_d, threshold_q;
  logic            valid_d, valid_q;

  // Strictly positive in two's complement: sign bit clear and not all zero.
  always_comb begin
    pos_mask = '0;
    for (int k = 0; k < BINS; k++) begin
      pos_mask[k] = ~i_histogram_chunk[k*DW + DW-1] &
                    (|i_histogram_chunk[k*DW +: DW]);
    end
  end

  last_pos_encoder #(.BINS(BINS), .PW(PW)) u_enc (
    .i_mask  (pos_mask),
    .o_found (found),
    .o_pos   (pos)
  );

  // 8-bit sum wraps by construction; "none found" reports 0.
  always_comb begin
    threshold_d = threshold_q;
    valid_d     = i_valid;
    if (i_valid) begin
      threshold_d = found ? bin_idx_t'(i_bin_index + IDX_W'(pos)) : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      threshold_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      threshold_q <= threshold_d;
      valid_q     <= valid_d;
    end
  end

  assign o_threshold = threshold_q;
  assign o_valid     = valid_q;

  generate
    if (TOP != 0) begin : g_top
    end else begin : g_sub
    end
  endgenerate

endmodule

// File: tb/tb_threshold_chunk_search.sv
// tb/tb_threshold_chunk_search.sv - scoreboard bench for threshold_chunk_search
module tb_threshold_chunk_search;

  logic         clk = 1'b0;
  logic         rst;
  logic         vld;
  logic [135:0] chunk;
  logic [7:0]   idx;
  logic [7:0]   o_thr;
  logic         o_vld;

  threshold_chunk_search #(.TOP(0), .BINS(8), .DW(17)) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_valid           (vld),
    .i_histogram_chunk (chunk),
    .i_bin_index       (idx),
    .o_threshold       (o_thr),
    .o_valid           (o_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] t;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  logic [7:0] model_thr = 8'd0;

  // Reference: walk bins from the top down, first strictly positive wins.
  function automatic logic [7:0] ref_search(input logic [135:0] c, input logic [7:0] base);
    int s;
    for (int k = 7; k >= 0; k--) begin
      s = int'($signed(c[k*17 +: 17]));
      if (s > 0) return 8'((int'(base) + k) % 256);
    end
    return 8'd0;
  endfunction

  function automatic logic [135:0] put(input logic [135:0] c, input int k, input int val);
    logic [135:0] r;
    logic [16:0]  v17;
    r = c;
    v17 = 17'(val);
    r[k*17 +: 17] = v17;
    return r;
  endfunction

  function automatic logic [135:0] fill(input int val);
    logic [135:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = put(r, k, val);
    return r;
  endfunction

  task automatic apply(input logic r, input logic v, input logic [135:0] c,
                       input logic [7:0] b, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r; vld = v; chunk = c; idx = b;
    if (r)      model_thr = 8'd0;
    else if (v) model_thr = ref_search(c, b);
    e.v = !r && v;
    e.t = model_thr;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected record per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (o_vld !== e.v || o_thr !== e.t) begin
          n_fail++;
          $display("FAIL %s: got valid=%0b thr=%0d, expected valid=%0b thr=%0d",
                   e.tag, o_vld, o_thr, e.v, e.t);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [135:0] c;
    int sel;
    rst = 1'b1; vld = 1'b0; chunk = '0; idx = 8'd0;

    apply(1, 0, '0, 8'd0, "reset");
    apply(1, 1, fill(5), 8'd9, "reset_with_valid");
    apply(0, 0, '0, 8'd0, "post_reset_idle");

    apply(0, 1, '0, 8'd40, "all_zero");
    c = fill(-3); c = put(c, 2, 1); c = put(c, 5, 1);
    apply(0, 1, c, 8'd16, "bins_2_5");
    c = fill(-1); c = put(c, 7, 'h0FFFF); c = put(c, 6, 'h10000);
    apply(0, 1, c, 8'd248, "max_pos_bin7");
    c = fill(-1); c = put(c, 6, 3);
    apply(0, 1, c, 8'd248, "bin6_only");
    c = fill(-7); c = put(c, 0, 5);
    apply(0, 1, c, 8'd8, "bin0_idx8");
    apply(0, 1, c, 8'd0, "bin0_idx0");
    c = fill(0); c = put(c, 3, 2);
    apply(0, 1, c, 8'd0, "b2b_first");
    c = fill(0); c = put(c, 1, 2);
    apply(0, 1, c, 8'd24, "b2b_second");
    apply(0, 0, fill(9), 8'd100, "hold_after_b2b");
    apply(0, 0, '0, 8'd0, "hold_again");
    c = fill(-2); c = put(c, 4, 1);
    apply(1, 1, c, 8'd64, "reset_dominates");
    apply(0, 0, c, 8'd64, "release_no_valid");

    for (int n = 0; n < 400; n++) begin
      c = '0;
      for (int k = 0; k < 8; k++) begin
        sel = int'($urandom_range(0, 9));
        case (sel)
          0:       c = put(c, k, 0);
          1:       c = put(c, k, 'h0FFFF);
          2:       c = put(c, k, 'h10000);
          3:       c = put(c, k, int'($urandom_range(1, 65535)));
          4:       c = put(c, k, 1);
          default: c = put(c, k, -int'($urandom_range(1, 65536)));
        endcase
      end
      apply(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), c,
            8'($urandom), "random");
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked records, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
